// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: shared vectors, queue entry type and pointer sizing for the fetch front end
package cpu_fetch_pkg;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] ILLOP_VEC_DEF = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC_DEF  = 32'h8000_0008;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order ring of fetched words tracked by alloc/fill/rd pointers
module fetch_queue import cpu_fetch_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [31:0]               push_pc,
  input  logic                      fill_en,
  input  logic [31:0]               fill_instr,
  input  logic                      pop,
  input  logic                      flush,
  output logic [ptr_w(DEPTH)-1:0]   occ,
  output logic [ptr_w(DEPTH)-1:0]   in_flight,
  output logic                      out_valid,
  output entry_t                    head,
  output logic                      nxt_ok,
  output logic [31:0]               nxt_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  typedef logic [PW-1:0] ptr_t;
  entry_t ring_q [DEPTH];
  entry_t ring_d [DEPTH];
  ptr_t alloc_q, alloc_d, fill_q, fill_d, rd_q, rd_d, sel;
  assign occ       = alloc_q - rd_q;
  assign in_flight = alloc_q - fill_q;
  assign out_valid = rd_q != fill_q;
  assign head      = ring_q[rd_q[AW-1:0]];
  assign sel       = rd_q + ptr_t'(pop);
  assign nxt_ok    = sel != alloc_q;
  assign nxt_pc    = ring_q[sel[AW-1:0]].pc;
  // allocate on grant, fill on response, pop on delivery; a flush rewinds all pointers
  always_comb begin
    ring_d = ring_q;
    if (push) ring_d[alloc_q[AW-1:0]].pc = push_pc;
    if (fill_en) ring_d[fill_q[AW-1:0]].instr = fill_instr;
    alloc_d = flush ? '0 : alloc_q + ptr_t'(push);
    fill_d  = flush ? '0 : fill_q + ptr_t'(fill_en);
    rd_d    = flush ? '0 : rd_q + ptr_t'(pop);
  end
  // ring storage and pointer registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ring_q  <= '{default: '0};
      alloc_q <= '0;
      fill_q  <= '0;
      rd_q    <= '0;
    end else begin
      ring_q  <= ring_d;
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      rd_q    <= rd_d;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: decoupled instruction fetcher; FETCH_IRQ_EN enables interrupt entry and epc capture
module fetch_unit import cpu_fetch_pkg::*; #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEF,
  parameter logic [31:0] XADR_VEC  = XADR_VEC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        irq,
  output logic        irq_taken,
  output logic [31:0] epc
);
  localparam int PW = ptr_w(DEPTH);
  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t FULL = ptr_t'(DEPTH);
  logic        run_q, run_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, nxt_pc, target;
  ptr_t        drop_q, drop_d, occ, in_flight;
  logic        push, fill_en, pop, flush, irq_acc, nxt_ok;
  entry_t      head;
  assign imem_req  = run_q && occ != FULL && drop_q == '0;
  assign imem_addr = fetch_pc_q;
  assign push      = imem_req && imem_gnt;
  assign fill_en   = imem_rvalid && drop_q == '0;
  assign pop       = out_valid && out_ready;
  assign flush     = redirect_valid || irq_acc;
  assign target    = redirect_valid ? (redirect_pc[1:0] != 2'b00 ? ILLOP_VEC : redirect_pc) : XADR_VEC;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign out_pc4   = head.pc + 32'd4;
  assign irq_taken = irq_acc;
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_pc    (fetch_pc_q),
    .fill_en    (fill_en),
    .fill_instr (imem_rdata),
    .pop        (pop),
    .flush      (flush),
    .occ        (occ),
    .in_flight  (in_flight),
    .out_valid  (out_valid),
    .head       (head),
    .nxt_ok     (nxt_ok),
    .nxt_pc     (nxt_pc)
  );
  // next fetch address; on flush, every outstanding response not returned this cycle becomes stale
  always_comb begin
    run_d      = 1'b1;
    fetch_pc_d = flush ? target : fetch_pc_q + (push ? 32'd4 : 32'd0);
    drop_d     = drop_q - ptr_t'(imem_rvalid && drop_q != '0)
               + (flush ? in_flight + ptr_t'(push) - ptr_t'(fill_en) : '0);
  end
  // fetch pc, stale-response count and post-reset issue enable
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
    end else begin
      run_q      <= run_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
`ifdef FETCH_IRQ_EN
  logic [31:0] epc_q, epc_d;
  assign irq_acc = irq && !fetch_pc_q[31] && !redirect_valid;
  assign epc     = epc_q;
  // resume at the oldest allocated entry that survives this cycle, else at the fetch pc
  always_comb epc_d = irq_acc ? (nxt_ok ? nxt_pc : fetch_pc_q) : epc_q;
  // epc holds until the next interrupt entry
  always_ff @(posedge clk or negedge reset)
    if (!reset) epc_q <= '0;
    else epc_q <= epc_d;
`else
  logic unused_irq;
  assign irq_acc    = 1'b0;
  assign epc        = '0;
  assign unused_irq = ^{irq, nxt_ok, nxt_pc};
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: fetch_unit bench with in-order variable-latency memory and stream-level reference model
module tb_fetch_unit;
`ifdef FETCH_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam logic [31:0] ILLOP = 32'h8000_0004;
  localparam logic [31:0] XADR  = 32'h8000_0008;
  logic clk = 1'b0;
  logic reset;
  logic imem_req, imem_gnt, out_valid, irq_taken;
  logic imem_rvalid = 1'b0;
  logic [31:0] imem_addr, out_instr, out_pc, out_pc4, epc;
  logic [31:0] imem_rdata = 32'h0;
  logic out_ready = 1'b0, redirect_valid = 1'b0, irq = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  bit gnt_en = 1'b0;
  int gnt_pct = 100, lat_min = 1, lat_max = 1, cyc = 0;
  logic [31:0] mq_addr[$];
  int mq_due[$];
  int nvec = 0, nbad = 0, delivered = 0;
  logic [31:0] exp_pc = 32'h0, exp_epc = 32'h0;
  bit kernel = 1'b0;
  typedef struct { logic [31:0] rpc; logic [31:0] want; } redir_vec_t;
  redir_vec_t tbl [8];

  always #5 clk = ~clk;
  assign imem_gnt = imem_req & gnt_en;

  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc4(out_pc4), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .irq(irq), .irq_taken(irq_taken), .epc(epc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a_c3c3;
  endfunction

  // memory: accepts granted requests, answers in order after a per-request latency
  always @(posedge clk or negedge reset)
    if (!reset) begin
      mq_addr.delete();
      mq_due.delete();
      cyc <= 0;
    end else begin
      if (imem_rvalid) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (imem_req && imem_gnt) begin
        mq_addr.push_back(imem_addr);
        mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      end
      cyc <= cyc + 1;
    end

  always @(negedge clk) begin
    imem_rvalid = mq_addr.size() != 0 && mq_due[0] <= cyc;
    imem_rdata  = imem_rvalid ? mem_word(mq_addr[0]) : 32'hdead_beef;
  end

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
    end
  endfunction

  // reference: delivered pcs form a sequential stream restarted by each redirect or interrupt
  function automatic void model();
    bit take;
    if (out_valid && out_ready) begin
      chk("out_pc", out_pc, exp_pc);
      chk("out_instr", out_instr, mem_word(exp_pc));
      chk("out_pc4", out_pc4, exp_pc + 32'd4);
      exp_pc += 32'd4;
      delivered++;
    end
    take = IRQ_EN && irq && !redirect_valid && !kernel;
    chk("irq_taken", 32'(irq_taken), 32'(take));
    chk("epc", epc, exp_epc);
    if (redirect_valid) begin
      exp_pc = redirect_pc[1:0] != 2'b00 ? ILLOP : redirect_pc;
      kernel = exp_pc[31];
    end else if (take) begin
      exp_epc = exp_pc;
      exp_pc  = XADR;
      kernel  = 1'b1;
    end
  endfunction

  task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc, input bit ir);
    @(negedge clk);
    out_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    irq = ir;
    gnt_en = $urandom_range(99, 0) < gnt_pct;
    #1;
    model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    irq = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_pc4", out_pc4, 32'h4);
    chk("rst_irq_taken", 32'(irq_taken), 32'h0);
    chk("rst_epc", epc, 32'h0);
    reset = 1'b1;
    exp_pc = 32'h0;
    exp_epc = 32'h0;
    kernel = 1'b0;
  endtask

  task automatic run_until_valid(input string nm, input logic [31:0] want);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      if (out_valid) begin
        chk(nm, out_pc, want);
        return;
      end
    end
    nvec++;
    nbad++;
    $display("FAIL %s: no out_valid within 40 cycles, expected pc %h", nm, want);
  endtask

  initial begin
    int d0, gnts, rd_start;
    bit seen;
    logic [31:0] rpc;
    tbl[0] = '{32'h0000_0100, 32'h0000_0100};
    tbl[1] = '{32'h0000_0102, ILLOP};
    tbl[2] = '{32'h0000_0101, ILLOP};
    tbl[3] = '{32'h0000_0203, ILLOP};
    tbl[4] = '{32'h0000_0ffc, 32'h0000_0ffc};
    tbl[5] = '{32'h7fff_fff0, 32'h7fff_fff0};
    tbl[6] = '{32'hffff_fff8, 32'hffff_fff8};
    tbl[7] = '{32'h8000_0000, 32'h8000_0000};
    reset = 1'b1;
    #1;
    // zero-wait memory, decode always ready: one word per cycle from cycle 3
    do_reset();
    d0 = delivered;
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      if (k == 1) chk("first_req", 32'(imem_req), 32'h1);
      chk("first_valid", 32'(out_valid), 32'(k >= 3));
    end
    chk("stream_count", 32'(delivered - d0), 32'd18);
    // backpressure: exactly DEPTH grants, then issue stops until decode drains
    do_reset();
    gnts = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      if (imem_req && imem_gnt) gnts++;
    end
    chk("bp_gnts", 32'(gnts), 32'd4);
    chk("bp_req_off", 32'(imem_req), 32'h0);
    chk("bp_head", out_pc, 32'h0);
    d0 = delivered;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      if (imem_req && imem_gnt) gnts++;
    end
    chk("bp_drain", 32'(delivered - d0), 32'd8);
    chk("bp_resume", 32'(gnts > 4), 32'h1);
    // 3-cycle memory: redirect with two fetches in flight drops both responses
    do_reset();
    lat_min = 3;
    lat_max = 3;
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0100, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("drop_req_off", 32'(imem_req), 32'h0);
    run_until_valid("redir_lat3", 32'h0000_0100);
    // table of redirect targets, including misaligned and wrapping ones
    do_reset();
    lat_min = 1;
    lat_max = 3;
    gnt_pct = 80;
    for (int t = 0; t < 8; t++) begin
      step(1'b1, 1'b1, tbl[t].rpc, 1'b0);
      run_until_valid("redir_tbl", tbl[t].want);
      repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
    end
    // interrupt with unpopped head at 0x40, then masked in kernel mode
    do_reset();
    lat_min = 1;
    lat_max = 1;
    gnt_pct = 100;
    step(1'b0, 1'b1, 32'h0000_0040, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      seen = out_valid;
    end
    chk("irq_head", out_pc, 32'h0000_0040);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("irq_pulse", 32'(irq_taken), 32'(IRQ_EN));
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("irq_epc", epc, IRQ_EN ? 32'h0000_0040 : 32'h0);
    chk("irq_pulse_end", 32'(irq_taken), 32'h0);
    run_until_valid("irq_target", IRQ_EN ? XADR : 32'h0000_0040);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      chk("irq_masked", 32'(irq_taken), 32'h0);
    end
    step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    chk("irq_vs_redirect", 32'(irq_taken), 32'h0);
    run_until_valid("redirect_wins", 32'h0000_0200);
    // randomized traffic against the stream model, with one mid-run reset
    do_reset();
    rd_start = delivered;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if (i % 200 == 0) begin
        lat_min = int'($urandom_range(2, 1));
        lat_max = lat_min + int'($urandom_range(3, 0));
        gnt_pct = int'($urandom_range(100, 30));
      end
      case ($urandom_range(3, 0))
        0: rpc = $urandom & 32'h0000_fffc;
        1: rpc = $urandom & 32'h0000_ffff;
        2: rpc = 32'h8000_0000 | ($urandom & 32'h0000_fffc);
        default: rpc = $urandom & 32'h0000_3ffc;
      endcase
      step($urandom_range(99, 0) < 75, $urandom_range(99, 0) < 3, rpc, $urandom_range(99, 0) < 8);
    end
    chk("rand_liveness", 32'(delivered - rd_start > 300), 32'h1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
